// File: rtl/glb_interleaved_stream_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : glb_interleaved_stream_buffer_if
//  Description : Command, status and valid/ready stream bundle for the
//                interleaved global buffer. "slave" is the buffer side,
//                "master" is the DMA / bench side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface glb_interleaved_stream_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    // command / status
    logic                  start;
    logic                  mode;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   num_words;
    logic                  busy;
    logic                  done;
    logic                  err;

    // load stream (into memory)
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    // dump stream (out of memory)
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    // sticky integrity flag
    logic                  parity_err;

    modport master (
        output start, mode, base_addr, num_words, s_data, s_valid, m_ready,
        input  busy, done, err, s_ready, m_data, m_valid, parity_err
    );

    modport slave (
        input  start, mode, base_addr, num_words, s_data, s_valid, m_ready,
        output busy, done, err, s_ready, m_data, m_valid, parity_err
    );
endinterface

`default_nettype wire

// File: rtl/glb_interleaved_stream_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : glb_interleaved_stream_buffer
//  Description : Global buffer made of NUM_BANKS interleaved single-port
//                banks. A command FSM streams a block of words in (load) or
//                out (dump) over valid/ready ports. Low address bits select
//                the bank, upper bits select the row.
//                Optional macro GLB_STREAM_PARITY_EN adds an even-parity bit
//                per stored word and a sticky parity_err on dump reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module glb_interleaved_stream_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 16384
) (
    input  logic                          clk,
    input  logic                          rst_n,
    glb_interleaved_stream_buffer_if.slave bus
);

    localparam int c_bank_bits = $clog2(NUM_BANKS);
    localparam int c_row_bits  = $clog2(BANK_DEPTH);
`ifdef GLB_STREAM_PARITY_EN
    localparam int c_word_w    = DATA_WIDTH + 1;
`else
    localparam int c_word_w    = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH+1:0] c_capacity = (ADDR_WIDTH+2)'(NUM_BANKS * BANK_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    // command progress
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH:0]     r_remaining;
    logic                    r_err;

    // dump read pipeline and 2-entry output FIFO
    logic                    r_inflight;
    logic [c_bank_bits-1:0]  r_rd_bank;
    logic [DATA_WIDTH-1:0]   r_fifo [2];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_count;

    // combinational control
    logic [c_bank_bits-1:0]  w_bank;
    logic [c_row_bits-1:0]   w_row;
    logic                    w_load_hs;
    logic                    w_pop;
    logic                    w_rd_en;
    logic                    w_wr_en;
    logic [c_word_w-1:0]     w_wr_word;
    logic [c_word_w-1:0]     w_bank_q [NUM_BANKS];
    logic [c_word_w-1:0]     w_rd_word;
    logic [ADDR_WIDTH+1:0]   w_end_sum;
    logic                    w_cmd_go;
    logic                    w_cmd_err;
    logic                    w_busy;
    logic                    w_done;
    logic                    w_err;
    logic                    w_s_ready;

    assign w_bank    = r_addr[c_bank_bits-1:0];
    assign w_row     = r_addr[c_bank_bits +: c_row_bits];
    assign w_end_sum = {2'b00, bus.base_addr} + {1'b0, bus.num_words};

    assign w_load_hs = (r_state == ST_LOAD) && bus.s_valid;
    assign w_wr_en   = w_load_hs;
    assign w_pop     = (r_count != 2'd0) && bus.m_ready;

    // Count a same-cycle pop as free space so a held m_ready sustains one
    // word per cycle while never exceeding the two FIFO slots.
    assign w_rd_en   = (r_state == ST_DUMP) && (r_remaining != '0) &&
                       (({1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop}) < 3'd2);

`ifdef GLB_STREAM_PARITY_EN
    assign w_wr_word = {^bus.s_data, bus.s_data};
`else
    assign w_wr_word = bus.s_data;
`endif

    assign w_rd_word = w_bank_q[r_rd_bank];

    // Interleaved banks: only the addressed bank is touched in a cycle.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [c_word_w-1:0] r_mem [BANK_DEPTH];
        logic [c_word_w-1:0] r_q;

        // Single-port bank: write on load handshake, registered read on dump issue.
        always_ff @(posedge clk) begin
            if (w_wr_en && (w_bank == c_bank_bits'(b))) begin
                r_mem[w_row] <= w_wr_word;
            end
            if (w_rd_en && (w_bank == c_bank_bits'(b))) begin
                r_q <= r_mem[w_row];
            end
        end

        assign w_bank_q[b] = r_q;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_go    = 1'b0;
        w_cmd_err   = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_s_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.num_words == '0) begin
                        w_state_nxt = ST_FIN;
                    end else if (w_end_sum > c_capacity) begin
                        w_cmd_err   = 1'b1;
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_cmd_go    = 1'b1;
                        w_state_nxt = bus.mode ? ST_DUMP : ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                w_busy    = 1'b1;
                w_s_ready = 1'b1;
                if (bus.s_valid && (r_remaining == (ADDR_WIDTH+1)'(1))) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_DUMP: begin
                w_busy = 1'b1;
                // last word leaves the FIFO with nothing left to fetch
                if ((r_remaining == '0) && !r_inflight && (r_count == 2'd1) && bus.m_ready) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                w_done      = 1'b1;
                w_err       = r_err;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command latch and address/remaining advance per load handshake or dump read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_err       <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && bus.start) begin
                r_err <= w_cmd_err;
            end
            if (w_cmd_go) begin
                r_addr      <= bus.base_addr;
                r_remaining <= bus.num_words;
            end else if (w_load_hs || w_rd_en) begin
                r_addr      <= r_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
            end
        end
    end

    // Read-return tracking and the 2-entry output FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_rd_bank  <= '0;
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_rd_bank <= w_bank;
            end
            if (r_inflight) begin
                r_fifo[r_wr_ptr] <= w_rd_word[DATA_WIDTH-1:0];
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

`ifdef GLB_STREAM_PARITY_EN
    logic r_parity_err;

    // Sticky parity flag: any returning dump word with odd overall parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else if (r_inflight && (^w_rd_word)) begin
            r_parity_err <= 1'b1;
        end
    end

    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.err     = w_err;
    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = (r_count != 2'd0);
    assign bus.m_data  = r_fifo[r_rd_ptr];

endmodule

`default_nettype wire
